adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_WID, default 8, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter NREQ, default 4, number of requesters; SHALL be in the range 2 to 8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  high SHALL allow new grants; low SHALL block new grants only.
REQ-006 req  input  NREQ  per-requester request, level, held until that requester's done.
REQ-007 a_in  input  NREQ*DATA_WID  operand A; requester i occupies bits [i*DATA_WID +: DATA_WID].
REQ-008 b_in  input  NREQ*DATA_WID  operand B, packed the same way as a_in.
REQ-009 grant  output  NREQ  one-hot registered grant; all zero when idle.
REQ-010 out  output  DATA_WID  registered sum for the granted requester.
REQ-011 overflow  output  1  registered overflow flag for the granted requester.
REQ-012 done  output  1  one-cycle pulse; out/overflow valid for the requester flagged in grant.

Function
REQ-013 The block SHALL instantiate exactly one adder instance of width DATA_WID, shared by all requesters.
REQ-014 The adder SHALL be driven only from internal operand registers, never directly from a_in/b_in.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 IDLE: if enable=1 and req!=0, select a winner, register its operands, set grant to winner, go to CALC; otherwise stay in IDLE.
REQ-017 CALC: register adder sum into out and overflow into overflow, assert done next cycle, go to DONE.
REQ-018 DONE: done=1 for exactly this cycle, grant held, then grant cleared and state goes to IDLE.
REQ-019 Latency SHALL be exactly 2 cycles from IDLE winner selection to done=1; one grant per 3 cycles maximum throughput.
REQ-020 Arbitration SHALL be round-robin: search starts at index (last_winner+1) mod NREQ, ascending with wrap.
REQ-021 last_winner SHALL update only on a grant; after reset the search SHALL start at index 0.
REQ-022 out SHALL equal (A+B) mod 2^DATA_WID; overflow SHALL equal A[MSB] AND B[MSB] of the captured operands.
REQ-023 Operands SHALL be captured once at grant; a_in/b_in changes during CALC/DONE SHALL not affect the result.
REQ-024 Dropping req of the granted requester mid-operation SHALL not abort; done still pulses.
REQ-025 enable=0 during CALC/DONE SHALL not stall the in-flight operation.
REQ-026 out and overflow SHALL hold their last value outside DONE; only done qualifies them.
REQ-027 grant SHALL never have more than one bit set.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, grant=0, done=0, out=0, overflow=0, round-robin start index=0.
REQ-029 Reset asserted during CALC or DONE SHALL discard the operation with no done pulse.
REQ-030 The first grant after reset SHALL follow REQ-016 from the next edge with rst_n=1.

Verification
REQ-031 Single request: req=0001, A0=8'h0F, B0=8'h01 -> grant=0001 1 cycle later, done=1 2 cycles later, out=8'h10, overflow=0.
REQ-032 Wrap and overflow: req=0010, A1=8'hFF, B1=8'h81 -> out=8'h80, overflow=1, grant=0010 during done.
REQ-033 Fairness: req=1111 held for 12 cycles -> grants in order 0001,0010,0100,1000, one done per 3 cycles.
REQ-034 Enable gating: enable=0 with req=0100 -> grant stays 0 indefinitely; enable=1 -> grant=0100 next cycle.
REQ-035 Operand change: grant req0 with A0=8'h01, B0=8'h02, then A0=8'hAA in CALC -> out=8'h03.
REQ-036 Mid-op reset: rst_n=0 during CALC -> next cycle grant=0, done=0, out=0; req=0001 then -> grant=0001.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one registered adder among NREQ requesters.
// Each grant runs IDLE -> CALC -> DONE, so one result is produced every three cycles at most.

module adder_core #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);
  assign o_sum = i_a + i_b;
  assign o_ovf = i_a[W-1] & i_b[W-1];
endmodule

module adder_arbiter #(
  parameter int DATA_WID = 8,
  parameter int NREQ     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_WID-1:0] a_in,
  input  logic [NREQ*DATA_WID-1:0] b_in,
  output logic [NREQ-1:0]          grant,
  output logic [DATA_WID-1:0]      out,
  output logic                     overflow,
  output logic                     done
);
  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_start;
  logic [NREQ-1:0]     r_grant;
  logic [DATA_WID-1:0] r_a;
  logic [DATA_WID-1:0] r_b;
  logic [DATA_WID-1:0] r_out;
  logic                r_ovf;
  logic                r_done;

  logic [2*NREQ-1:0]   w_req_dbl;
  logic [NREQ-1:0]     w_req_rot;
  logic                w_found;
  logic [IDX_W-1:0]    w_offset;
  logic [IDX_W:0]      w_pos;
  logic [IDX_W:0]      w_win;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W:0]      w_inc;
  logic [IDX_W-1:0]    w_next_start;
  logic [NREQ-1:0]     w_grant_sel;
  logic [DATA_WID-1:0] w_a_sel;
  logic [DATA_WID-1:0] w_b_sel;
  logic [DATA_WID-1:0] w_sum;
  logic                w_ovf;
  logic                w_load;
  logic                w_calc;
  logic                w_finish;

  // Rotating the doubled request vector puts the search start at bit 0.
  assign w_req_dbl = {req, req} >> r_start;
  assign w_req_rot = w_req_dbl[NREQ-1:0];
  assign w_found   = |w_req_rot;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_offset = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (w_req_rot[k]) w_offset = IDX_W'(k);
    end
    w_pos        = {1'b0, r_start} + {1'b0, w_offset};
    w_win        = (w_pos >= NREQ_W) ? (w_pos - NREQ_W) : w_pos;
    w_win_idx    = w_win[IDX_W-1:0];
    w_inc        = {1'b0, w_win_idx} + (IDX_W+1)'(1);
    w_next_start = (w_inc == NREQ_W) ? '0 : w_inc[IDX_W-1:0];
    w_grant_sel  = NREQ'(1) << w_win_idx;
  end

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win_idx == IDX_W'(k)) begin
        w_a_sel = a_in[k*DATA_WID +: DATA_WID];
        w_b_sel = b_in[k*DATA_WID +: DATA_WID];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_calc   = (r_state == CALC);
  assign w_finish = (r_state == DONE);

  adder_core #(.W(DATA_WID)) u_adder (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= '0;
      r_grant <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_calc;
      if (w_load) begin
        r_grant <= w_grant_sel;
        r_start <= w_next_start;
      end else if (w_finish) begin
        r_grant <= '0;
      end
      if (w_calc) begin
        r_out <= w_sum;
        r_ovf <= w_ovf;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only consumed after a grant has loaded them.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= w_a_sel;
      r_b <= w_b_sel;
    end
  end

  assign grant    = r_grant;
  assign out      = r_out;
  assign overflow = r_ovf;
  assign done     = r_done;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed sequences with a result scoreboard
// popped on every done pulse, plus cycle-exact grant/done timing checks.

module tb_adder_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] a_in;
  logic [NR*DW-1:0] b_in;
  logic [NR-1:0]    grant;
  logic [DW-1:0]    out;
  logic             overflow;
  logic             done;

  typedef struct {
    logic [NR-1:0] grant;
    logic [DW-1:0] sum;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  adder_arbiter #(.DATA_WID(DW), .NREQ(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .grant    (grant),
    .out      (out),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_in[idx*DW +: DW] = a;
    b_in[idx*DW +: DW] = b;
  endtask

  // Reference result: modular sum and MSB-and overflow of the captured operands.
  task automatic expect_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [DW:0] full;
    full    = {1'b0, a} + {1'b0, b};
    e.grant = NR'(1) << idx;
    e.sum   = full[DW-1:0];
    e.ovf   = a[DW-1] & b[DW-1];
    sb.push_back(e);
  endtask

  // Scoreboard monitor plus one-hot grant invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      if (done) begin
        check("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_grant", 32'(grant), 32'(e.grant));
          check("sb_out", 32'(out), 32'(e.sum));
          check("sb_ovf", 32'(overflow), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Single request, first grant after reset.
    set_op(0, 8'h0F, 8'h01);
    req = 4'b0001;
    expect_op(0, 8'h0F, 8'h01);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    req = '0;
    tick();
    check("t1_grant_clr", 32'(grant), 32'd0);
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_out_hold", 32'(out), 32'h10);

    // Wrap-around sum with overflow.
    set_op(1, 8'hFF, 8'h81);
    req = 4'b0010;
    expect_op(1, 8'hFF, 8'h81);
    tick();
    check("t2_grant", 32'(grant), 32'h2);
    tick();
    check("t2_done", 32'(done), 32'd1);
    req = '0;
    tick();

    // Operands change and enable drops while the operation is in flight.
    set_op(0, 8'h01, 8'h02);
    req = 4'b0001;
    expect_op(0, 8'h01, 8'h02);
    tick();
    check("t3_grant", 32'(grant), 32'h1);
    set_op(0, 8'hAA, 8'h55);
    enable = 1'b0;
    req    = '0;
    tick();
    check("t3_done", 32'(done), 32'd1);
    tick();
    enable = 1'b1;

    // Enable gating holds off a pending request.
    enable = 1'b0;
    req    = 4'b0100;
    set_op(2, 8'h30, 8'h40);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_gated", 32'(grant), 32'd0);
    end
    enable = 1'b1;
    expect_op(2, 8'h30, 8'h40);
    tick();
    check("t4_grant", 32'(grant), 32'h4);
    tick();
    check("t4_done", 32'(done), 32'd1);
    req = '0;
    tick();

    // Fairness from a fresh reset: all four requesting for 12 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      set_op(i, DW'(8'h40 * i + 8'h3F), DW'(8'h80 | i));
      expect_op(i, DW'(8'h40 * i + 8'h3F), DW'(8'h80 | i));
    end
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("t5_grant", 32'(grant), (c % 3 == 2) ? 32'd0 : 32'(NR'(1) << (c / 3)));
      check("t5_done", 32'(done), (c % 3 == 1) ? 32'd1 : 32'd0);
    end
    req = '0;
    tick();

    // Reset during CALC discards the operation; next grant follows release.
    set_op(0, 8'h11, 8'h22);
    req = 4'b0001;
    tick();
    check("t6_grant", 32'(grant), 32'h1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_out", 32'(out), 32'd0);
    rst_n = 1'b1;
    expect_op(0, 8'h11, 8'h22);
    tick();
    check("t6_regrant", 32'(grant), 32'h1);
    tick();
    check("t6_done", 32'(done), 32'd1);
    req = '0;
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
